hamming_enc_pipe: RTL and testbench
===================================

// Module: hamming_enc_pipe
// PURPOSE
//  Parametrised, pipelined Hamming SEC encoder with an overall (SECDED) parity bit and valid/ready flow control.
//  Generalises the fixed 4-bit (7,4) encoder to any DATA_W and adds backpressure, a 2-stage pipeline and an accepted-word counter.
//  Sits between a data source and the storage/link write path; the output codeword feeds memory or a serialiser.
// PARAMETERS
//  DATA_W   4   data bits per word, 1..57
//  COUNT_W  16  width of the accepted-word counter
//  localparam PAR_W  = smallest r with 2**r >= DATA_W+r+1 (DATA_W=4 -> 3, 8 -> 4, 32 -> 6)
//  localparam CODE_W = DATA_W+PAR_W
// PORTS
//  i_clk           in   1        clock; all logic on its rising edge
//  i_rst           in   1        reset, asynchronous, active-high
//  i_valid         in   1        input word valid
//  o_ready         out  1        block can accept a word
//  i_data          in   DATA_W   data word
//  o_valid         out  1        output codeword valid
//  i_ready         in   1        downstream accepts codeword
//  o_hamming_code  out  CODE_W   codeword, bit k = 1-based position k+1
//  o_parity        out  1        XOR of all o_hamming_code bits (even overall parity)
//  o_count         out  COUNT_W  number of input words accepted since reset
// BEHAVIOUR
//  - Layout: positions 2**j (1-based) hold parity p(2**j); data bits fill the remaining positions in ascending order, d0 lowest.
//    DATA_W=4 gives {d3,d2,d1,p4,d0,p2,p1}.
//  - p(2**j) = XOR of all data bits whose 1-based position has bit j set.
//  - Accept occurs when i_valid && o_ready. Output transfer occurs when o_valid && i_ready.
//  - Stage 1 registers the data word. Stage 2 registers the codeword and o_parity.
//    Latency is 2 cycles from accept to o_valid when there is no stall.
//  - Each stage holds a valid flag; a stage loads when it is empty or when its contents move on the same cycle.
//    o_ready = !s1_valid || (!s2_valid || i_ready). This gives full throughput of 1 word per cycle.
//  - Stall: with i_ready low, o_hamming_code, o_parity and o_valid hold stable; no word is dropped or duplicated.
//    Both stages can be full (2 words buffered).
//  - o_ready depends combinationally on i_ready. No other combinational path runs from input to output.
//  - o_count increments by 1 per accept and wraps from 2**COUNT_W-1 to 0.
//  - Simultaneous accept and output transfer: both occur; occupancy is unchanged.
//  - Reset (any time, including mid-stall) does the following:
//    o_valid=0, o_hamming_code=0, o_parity=0, o_count=0, all stage valids=0; in-flight words are discarded.
//    o_ready=1 after reset deasserts.
//  - i_data is ignored when i_valid=0. Outputs when o_valid=0 hold their last value (0 after reset).
// CONFIGURATION
//  HAMM_ENC_ERR_INJ_EN defined:
//    - Adds ports i_inj_en (in 1) and i_inj_pos (in $clog2(CODE_W)).
//    - When i_inj_en=1 at accept, the word's stage-2 codeword bit i_inj_pos is inverted after the parity computation.
//    - o_parity is computed over the uncorrupted codeword, so single-bit injection yields a correctable single error.
//    - If i_inj_pos >= CODE_W, no bit is flipped.
//  Not defined: the ports are absent and the codeword is always clean; no extra logic is generated.
// TESTING
//  1 DATA_W=4, i_data=4'hB accepted, i_ready=1 -> 2 cycles later o_hamming_code=7'h55, o_parity=0, o_count=1.
//  2 DATA_W=4, back-to-back 4'h0, 4'hF, 4'hB with i_ready=1 -> outputs 7'h00/p0, 7'h7F/p1, 7'h55/p0 on consecutive cycles, o_ready stays 1.
//  3 DATA_W=8, i_data=8'h01 -> o_hamming_code=12'h007, o_parity=1. Also sweep all 256 words and compare against a reference model.
//  4 Stall: i_ready=0 while sending 3 words -> o_ready falls after 2 accepts; o_valid/code stable; releasing i_ready delivers all 3 words in order.
//  5 Assert i_rst mid-stall with 2 words buffered -> o_valid=0, o_count=0 immediately; no stale word appears after reset.
//  6 HAMM_ENC_ERR_INJ_EN, DATA_W=4, 4'hB with i_inj_pos=2 -> code 7'h51, o_parity=0. COUNT_W=2: 5 accepts -> o_count=1 (wrap).

Source files
------------

// File: rtl/hamming_enc_pipe.sv
// hamming_enc_pipe
//   Parametrised two-stage pipelined Hamming SEC encoder with an overall
//   (SECDED) parity output and valid/ready flow control on both sides.
//
//   Codeword layout: bit k holds 1-based position k+1. Power-of-two positions
//   carry parity bits, and data bits fill the remaining positions in ascending
//   order, d0 lowest. For DATA_W=4 the layout is {d3,d2,d1,p4,d0,p2,p1}.
//
//   Optional feature macro: HAMM_ENC_ERR_INJ_EN. It adds single-bit error
//   injection on the stage-2 codeword. The injected flip is applied after
//   o_parity has been computed.
//
// Ports
//   i_clk           clock, rising edge
//   i_rst           asynchronous active-high reset
//   i_valid/o_ready input handshake; carries i_data [DATA_W-1:0]
//   o_valid/i_ready output handshake; carries o_hamming_code [CODE_W-1:0]
//                   and o_parity
//   o_count         number of input words accepted since reset (wraps)
//   i_inj_en        (HAMM_ENC_ERR_INJ_EN only) inject an error into this word
//   i_inj_pos       (HAMM_ENC_ERR_INJ_EN only) codeword bit to invert; values
//                   >= CODE_W leave the word clean
module hamming_enc_pipe #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned COUNT_W = 16,
  // PAR_W is the smallest r with 2**r >= DATA_W + r + 1.
  localparam int unsigned PAR_W  = (DATA_W + 3 <= 4)  ? 2 :
                                   (DATA_W + 4 <= 8)  ? 3 :
                                   (DATA_W + 5 <= 16) ? 4 :
                                   (DATA_W + 6 <= 32) ? 5 :
                                   (DATA_W + 7 <= 64) ? 6 : 7,
  localparam int unsigned CODE_W = DATA_W + PAR_W,
  localparam int unsigned INJ_W  = $clog2(CODE_W)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [DATA_W-1:0]  i_data,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [CODE_W-1:0]  o_hamming_code,
  output logic               o_parity,
`ifdef HAMM_ENC_ERR_INJ_EN
  input  logic               i_inj_en,
  input  logic [INJ_W-1:0]   i_inj_pos,
`endif
  output logic [COUNT_W-1:0] o_count
);

  // Returns the 1-based codeword position of data bit idx, skipping the
  // power-of-two positions.
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned pos;
    int unsigned seen;
    pos  = 0;
    seen = 0;
    for (int unsigned p = 1; p <= CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (seen == idx) pos = p;
        seen++;
      end
    end
    return pos;
  endfunction

  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    logic              p;
    c = '0;
    for (int unsigned i = 0; i < DATA_W; i++) c[data_pos(i) - 1] = d[i];
    for (int unsigned j = 0; j < PAR_W; j++) begin
      p = 1'b0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
        if (((data_pos(i) >> j) & 1) != 0) p = p ^ d[i];
      end
      c[(1 << j) - 1] = p;
    end
    return c;
  endfunction

  logic               s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0]  s1_data_q,  s1_data_d;
  logic               s2_valid_q, s2_valid_d;
  logic [CODE_W-1:0]  code_q,     code_d;
  logic               parity_q,   parity_d;
  logic [COUNT_W-1:0] count_q,    count_d;

  logic               accept;
  logic               s2_load;
  logic [CODE_W-1:0]  code_clean;
  logic [CODE_W-1:0]  inj_mask;

`ifdef HAMM_ENC_ERR_INJ_EN
  logic               s1_inj_en_q,  s1_inj_en_d;
  logic [INJ_W-1:0]   s1_inj_pos_q, s1_inj_pos_d;
`endif

  // o_ready is the only combinational input-to-output path: stage 1 can take a
  // word if it is empty or if its word moves into stage 2 on this edge.
  always_comb begin
    s2_load = s1_valid_q && (!s2_valid_q || i_ready);
    o_ready = !s1_valid_q || (!s2_valid_q || i_ready);
    accept  = i_valid && o_ready;
  end

  always_comb begin
    code_clean = encode(s1_data_q);
    inj_mask   = '0;
`ifdef HAMM_ENC_ERR_INJ_EN
    // Out-of-range positions never match any k, so the word stays clean.
    for (int unsigned k = 0; k < CODE_W; k++) begin
      inj_mask[k] = s1_inj_en_q && (s1_inj_pos_q == INJ_W'(k));
    end
`endif
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    code_d     = code_q;
    parity_d   = parity_q;
    count_d    = count_q;
`ifdef HAMM_ENC_ERR_INJ_EN
    s1_inj_en_d  = s1_inj_en_q;
    s1_inj_pos_d = s1_inj_pos_q;
`endif

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_data_d  = i_data;
      count_d    = count_q + 1'b1;
`ifdef HAMM_ENC_ERR_INJ_EN
      s1_inj_en_d  = i_inj_en;
      s1_inj_pos_d = i_inj_pos;
`endif
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d = 1'b1;
      code_d     = code_clean ^ inj_mask;
      parity_d   = ^code_clean;
    end else if (s2_valid_q && i_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      code_q     <= '0;
      parity_q   <= 1'b0;
      count_q    <= '0;
`ifdef HAMM_ENC_ERR_INJ_EN
      s1_inj_en_q  <= 1'b0;
      s1_inj_pos_q <= '0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      code_q     <= code_d;
      parity_q   <= parity_d;
      count_q    <= count_d;
`ifdef HAMM_ENC_ERR_INJ_EN
      s1_inj_en_q  <= s1_inj_en_d;
      s1_inj_pos_q <= s1_inj_pos_d;
`endif
    end
  end

  assign o_valid        = s2_valid_q;
  assign o_hamming_code = code_q;
  assign o_parity       = parity_q;
  assign o_count        = count_q;

endmodule

// File: tb/tb_hamming_enc_pipe.sv
// tb_hamming_enc_pipe
//   Directed bench for hamming_enc_pipe. Instance A uses DATA_W=4 and
//   COUNT_W=16. Instance B uses DATA_W=8 and COUNT_W=2, which exercises the
//   counter wrap and the full 8-bit word sweep.
module tb_hamming_enc_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_valid, a_ordy, a_ovalid, a_iready, a_par;
  logic [3:0]  a_data;
  logic [6:0]  a_code;
  logic [15:0] a_count;
`ifdef HAMM_ENC_ERR_INJ_EN
  logic        a_inj_en;
  logic [2:0]  a_inj_pos;
  logic        b_inj_en;
  logic [3:0]  b_inj_pos;
`endif

  logic        b_valid, b_ordy, b_ovalid, b_iready, b_par;
  logic [7:0]  b_data;
  logic [11:0] b_code;
  logic [1:0]  b_count;

  int n_pass  = 0;
  int n_total = 0;

  hamming_enc_pipe #(.DATA_W(4), .COUNT_W(16)) u_a (
    .i_clk(clk), .i_rst(rst),
    .i_valid(a_valid), .o_ready(a_ordy), .i_data(a_data),
    .o_valid(a_ovalid), .i_ready(a_iready),
    .o_hamming_code(a_code), .o_parity(a_par),
`ifdef HAMM_ENC_ERR_INJ_EN
    .i_inj_en(a_inj_en), .i_inj_pos(a_inj_pos),
`endif
    .o_count(a_count)
  );

  hamming_enc_pipe #(.DATA_W(8), .COUNT_W(2)) u_b (
    .i_clk(clk), .i_rst(rst),
    .i_valid(b_valid), .o_ready(b_ordy), .i_data(b_data),
    .o_valid(b_ovalid), .i_ready(b_iready),
    .o_hamming_code(b_code), .o_parity(b_par),
`ifdef HAMM_ENC_ERR_INJ_EN
    .i_inj_en(b_inj_en), .i_inj_pos(b_inj_pos),
`endif
    .o_count(b_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: place the data bits, then each parity bit j is bit j of the XOR
  // of the positions of all set data bits, so the syndrome becomes zero.
  function automatic logic [11:0] ref_code8(input logic [7:0] d);
    logic [11:0] c;
    logic [3:0]  syn;
    int          di;
    c   = '0;
    syn = '0;
    di  = 0;
    for (int pos = 1; pos <= 12; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[di];
        if (d[di]) syn = syn ^ 4'(pos);
        di++;
      end
    end
    for (int j = 0; j < 4; j++) c[(1 << j) - 1] = syn[j];
    return c;
  endfunction

  // Streams n words first, first+1, ... through instance B with i_ready held
  // high and checks each delivered codeword in order against the reference.
  task automatic run_b(input int first, input int n);
    logic [7:0]  q[$];
    logic [7:0]  w;
    logic [11:0] exp_c;
    logic        acc, xfer;
    int          sent;
    int          cyc;
    sent     = 0;
    cyc      = 0;
    b_iready = 1'b1;
    while ((sent < n || q.size() != 0) && cyc < 1000) begin
      b_valid = (sent < n);
      b_data  = 8'(first + sent);
      #1;
      acc  = b_valid && b_ordy;
      xfer = b_ovalid && b_iready;
      if (xfer) begin
        if (q.size() == 0) begin
          check("b_unexpected_word", 64'(b_ovalid), 64'(0));
        end else begin
          w     = q.pop_front();
          exp_c = ref_code8(w);
          check("b_code", 64'(b_code), 64'(exp_c));
          check("b_par", 64'(b_par), 64'(^exp_c));
        end
      end
      if (acc) begin
        q.push_back(b_data);
        sent++;
      end
      step();
      cyc++;
    end
    b_valid = 1'b0;
    check("b_drain_budget", 64'(q.size()), 64'(0));
    check("b_idle_after_drain", 64'(b_ovalid), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    a_valid  = 1'b0; a_data = '0; a_iready = 1'b1;
    b_valid  = 1'b0; b_data = '0; b_iready = 1'b1;
`ifdef HAMM_ENC_ERR_INJ_EN
    a_inj_en = 1'b0; a_inj_pos = '0;
    b_inj_en = 1'b0; b_inj_pos = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_a_valid", 64'(a_ovalid), 64'(0));
    check("rst_a_code",  64'(a_code),   64'(0));
    check("rst_a_par",   64'(a_par),    64'(0));
    check("rst_a_count", 64'(a_count),  64'(0));
    check("rst_b_count", 64'(b_count),  64'(0));
    rst = 1'b0;
    #1;
    check("rst_a_ready", 64'(a_ordy), 64'(1));

    // Single word 4'hB, two-cycle latency.
    step();
    a_valid = 1'b1; a_data = 4'hB;
    step();
    a_valid = 1'b0;
    check("t1_not_yet", 64'(a_ovalid), 64'(0));
    step();
    check("t1_valid", 64'(a_ovalid), 64'(1));
    check("t1_code",  64'(a_code),   64'(7'h55));
    check("t1_par",   64'(a_par),    64'(0));
    check("t1_count", 64'(a_count),  64'(1));
    step();
    check("t1_done", 64'(a_ovalid), 64'(0));

    // Back-to-back 0, F, B at full throughput.
    a_valid = 1'b1; a_data = 4'h0; #1;
    check("t2_ready0", 64'(a_ordy), 64'(1));
    step();
    a_data = 4'hF; #1;
    check("t2_ready1", 64'(a_ordy), 64'(1));
    step();
    check("t2_code0", 64'({a_ovalid, a_par, a_code}), 64'({1'b1, 1'b0, 7'h00}));
    a_data = 4'hB; #1;
    check("t2_ready2", 64'(a_ordy), 64'(1));
    step();
    check("t2_codeF", 64'({a_ovalid, a_par, a_code}), 64'({1'b1, 1'b1, 7'h7F}));
    a_valid = 1'b0;
    step();
    check("t2_codeB", 64'({a_ovalid, a_par, a_code}), 64'({1'b1, 1'b0, 7'h55}));
    check("t2_count", 64'(a_count), 64'(4));
    step();
    check("t2_done", 64'(a_ovalid), 64'(0));

    // Stall with words 3, 5, 6.
    a_iready = 1'b0;
    a_valid = 1'b1; a_data = 4'h3; #1;
    check("t4_ready0", 64'(a_ordy), 64'(1));
    step();
    a_data = 4'h5; #1;
    check("t4_ready1", 64'(a_ordy), 64'(1));
    step();
    check("t4_first", 64'({a_ovalid, a_par, a_code}), 64'({1'b1, 1'b0, 7'h1E}));
    a_data = 4'h6; #1;
    check("t4_ready_low", 64'(a_ordy), 64'(0));
    step();
    check("t4_hold1", 64'({a_ovalid, a_par, a_code}), 64'({1'b1, 1'b0, 7'h1E}));
    check("t4_count2", 64'(a_count), 64'(6));
    step();
    check("t4_hold2", 64'({a_ovalid, a_par, a_code}), 64'({1'b1, 1'b0, 7'h1E}));
    a_iready = 1'b1; #1;
    check("t4_ready_release", 64'(a_ordy), 64'(1));
    step();
    a_valid = 1'b0;
    check("t4_second", 64'({a_ovalid, a_par, a_code}), 64'({1'b1, 1'b0, 7'h2D}));
    step();
    check("t4_third", 64'({a_ovalid, a_par, a_code}), 64'({1'b1, 1'b0, 7'h33}));
    step();
    check("t4_done", 64'(a_ovalid), 64'(0));
    check("t4_count", 64'(a_count), 64'(7));

    // Reset with two words buffered.
    a_iready = 1'b0;
    a_valid = 1'b1; a_data = 4'h9;
    step();
    a_data = 4'hA;
    step();
    a_valid = 1'b0; #1;
    check("t5_full", 64'({a_ovalid, a_ordy}), 64'({1'b1, 1'b0}));
    rst = 1'b1; #1;
    check("t5_rst_valid", 64'(a_ovalid), 64'(0));
    check("t5_rst_count", 64'(a_count), 64'(0));
    check("t5_rst_code",  64'({a_par, a_code}), 64'(0));
    step();
    rst = 1'b0; #1;
    check("t5_ready", 64'(a_ordy), 64'(1));
    a_iready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_no_stale", 64'(a_ovalid), 64'(0));
    end
    check("t5_count", 64'(a_count), 64'(0));

`ifdef HAMM_ENC_ERR_INJ_EN
    a_valid = 1'b1; a_data = 4'hB; a_inj_en = 1'b1; a_inj_pos = 3'd2;
    step();
    a_valid = 1'b0; a_inj_en = 1'b0;
    step();
    check("t6_inj_code", 64'({a_ovalid, a_code}), 64'({1'b1, 7'h51}));
    check("t6_inj_par",  64'(a_par), 64'(0));
    step();
    a_valid = 1'b1; a_data = 4'hB; a_inj_en = 1'b1; a_inj_pos = 3'd7;
    step();
    a_valid = 1'b0; a_inj_en = 1'b0;
    step();
    check("t6_inj_oob", 64'({a_ovalid, a_par, a_code}), 64'({1'b1, 1'b0, 7'h55}));
    step();
`endif

    // Instance B: 8'h01 by hand, then counter wrap and full sweep.
    b_valid = 1'b1; b_data = 8'h01;
    step();
    b_valid = 1'b0;
    step();
    check("t3_code01", 64'({b_ovalid, b_par, b_code}), 64'({1'b1, 1'b1, 12'h007}));
    check("t3_count1", 64'(b_count), 64'(1));
    step();
    run_b(2, 4);
    check("t6_wrap_count", 64'(b_count), 64'(1));
    run_b(0, 256);
    check("t3_sweep_count", 64'(b_count), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
